lfsr_run_ctrl: RTL and testbench

Sequencer for the 4-bit mode-selectable LFSR engine in the top-level wrapper. It takes a start request with a mode and a run length, and holds the LFSR in reset for a fixed clear window. It then releases the LFSR for exactly the requested number of clocks, captures the final LFSR value plus a rotate-XOR signature of every state seen, and reports completion with a one-cycle done pulse. It sits between the ui_in switches / host logic and the LFSR's reset and mod pins.

---
 rtl/lfsr_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_lfsr_run_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_run_ctrl.sv
// Run sequencer for the 4-bit mode-selectable LFSR: clear window, timed run, result/signature capture.
// Optional macro LFSR_RUN_CTRL_RUNCOUNT_EN adds a saturating count of completed runs (run_count).
module lfsr_run_ctrl #(
    parameter int DATA_W       = 4,
    parameter int LEN_W        = 8,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        mode,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] lfsr_q,
    output logic              lfsr_rst,
    output logic [2:0]        lfsr_mod,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] sig
`ifdef LFSR_RUN_CTRL_RUNCOUNT_EN
    ,
    output logic [7:0]        run_count
`endif
);

    // Counter must hold both the clear window (up to 15) and a full run length.
    localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [LEN_W-1:0] len_q;
    logic             accept;
    logic             abort_take;
    logic             run_step;
    logic             last_run;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        accept     = 1'b0;
        abort_take = 1'b0;
        last_run   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len == '0) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_CLEAR;
                        cnt_d   = CLR_LOAD;
                    end
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    abort_take = 1'b1;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end else if (cnt == '0) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_W'(len_q) - CNT_W'(1);
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (abort) begin
                    abort_take = 1'b1;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end else if (cnt == '0) begin
                    last_run = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // An abort in the final RUN cycle wins: no signature or result update.
    assign run_step = (state == S_RUN) && !abort;

    // Strobes are flopped from the next state so the LFSR reset line is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lfsr_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            lfsr_rst <= (state_d != S_RUN);
            busy     <= (state_d == S_CLEAR) || (state_d == S_RUN);
            done     <= (state_d == S_DONE);
            aborted  <= abort_take;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_mod <= 3'd0;
            len_q    <= '0;
            result   <= '0;
            sig      <= '0;
        end else if (accept) begin
            lfsr_mod <= mode;
            len_q    <= len;
            sig      <= '0;
            if (len == '0) begin
                result <= '0;
            end
        end else if (run_step) begin
            sig <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ lfsr_q;
            if (last_run) begin
                result <= lfsr_q;
            end
        end
    end

`ifdef LFSR_RUN_CTRL_RUNCOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_count <= 8'd0;
        end else if (state == S_DONE && run_count != 8'hFF) begin
            run_count <= run_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Self-checking bench for lfsr_run_ctrl: per-cycle phase profile and signature checked against a run-level model.
// Covers LFSR_RUN_CTRL_RUNCOUNT_EN when that macro is defined for the build.
module tb_lfsr_run_ctrl;
    localparam int C   = 2;
    localparam int MAXK = 300;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] mode  = 3'd0;
    logic [7:0] len   = 8'd0;
    logic [3:0] lfsr_q = 4'd0;
    logic       lfsr_rst, busy, done, aborted;
    logic [2:0] lfsr_mod;
    logic [3:0] result, sig;
`ifdef LFSR_RUN_CTRL_RUNCOUNT_EN
    logic [7:0] run_count;
`endif

    lfsr_run_ctrl #(.DATA_W(4), .LEN_W(8), .CLEAR_CYCLES(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .len(len),
        .lfsr_q(lfsr_q), .lfsr_rst(lfsr_rst), .lfsr_mod(lfsr_mod), .busy(busy), .done(done),
        .aborted(aborted), .result(result), .sig(sig)
`ifdef LFSR_RUN_CTRL_RUNCOUNT_EN
        , .run_count(run_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Per-cycle observations; index k = cycles after the edge that accepted start.
    logic       tr_rst [0:MAXK];
    logic       tr_busy[0:MAXK];
    logic       tr_done[0:MAXK];
    logic       tr_abt [0:MAXK];
    logic [2:0] tr_mod [0:MAXK];
    logic [3:0] tr_res [0:MAXK];
    logic [3:0] tr_sig [0:MAXK];
    logic [3:0] tr_q   [0:MAXK];

    int         q_src   = 0;      // 0 random, 1 bench LFSR, 2 constant
    logic [3:0] q_const = 4'd0;
    logic [3:0] lstate  = 4'h1;
    logic [3:0] exp_res_last = 4'd0;

    task automatic drive_q();
        if (q_src == 1) begin
            lstate = {lstate[2:0], lstate[3] ^ lstate[2]};
            lfsr_q = lstate;
        end else if (q_src == 2) begin
            lfsr_q = q_const;
        end else begin
            lfsr_q = 4'($urandom);
        end
    endtask

    task automatic launch(input logic [7:0] l, input logic [2:0] m, input int ncyc,
                          input int abort_k, input int restart_k, input bit abort_with_start);
        @(negedge clk);
        start = 1'b1; abort = abort_with_start; len = l; mode = m;
        drive_q();
        tr_q[0] = lfsr_q;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            tr_rst[k] = lfsr_rst; tr_busy[k] = busy; tr_done[k] = done; tr_abt[k] = aborted;
            tr_mod[k] = lfsr_mod; tr_res[k] = result; tr_sig[k] = sig;
            start = (k == restart_k);
            abort = (k == abort_k);
            mode  = 3'($urandom);
            len   = 8'($urandom);
            drive_q();
            tr_q[k] = lfsr_q;
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    // Expected {lfsr_rst, busy, done, aborted} in cycle k of a run of length l.
    function automatic logic [3:0] exp_flags(int k, int l, int abort_k);
        int end_k, done_k;
        logic r, b, d, a;
        end_k = (abort_k > 0) ? abort_k : C + l;
        if (l == 0 && abort_k <= 0) end_k = 0;
        done_k = (abort_k > 0) ? -1 : ((l == 0) ? 1 : C + l + 1);
        b = (k >= 1 && k <= end_k);
        r = !(k > C && k <= end_k);
        d = (k == done_k);
        a = (abort_k > 0 && k == abort_k + 1);
        return {r, b, d, a};
    endfunction

    // Signature = fold of rotate-left-by-one then XOR over the RUN-cycle samples.
    function automatic logic [3:0] model_sig(int first, int n);
        int s = 0;
        for (int i = 0; i < n; i++) begin
            s = ((s << 1) | (s >> 3)) & 15;
            s = s ^ int'(tr_q[first + i]);
        end
        return 4'(s);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (lfsr_rst !== 1'b1) begin fails++; $display("FAIL reset_lfsr_rst got %b want 1", lfsr_rst); end
        checks++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (aborted !== 1'b0)  begin fails++; $display("FAIL reset_aborted got %b want 0", aborted); end
        checks++; if (result !== 4'd0)   begin fails++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (sig !== 4'd0)      begin fails++; $display("FAIL reset_sig got %h want 0", sig); end
        checks++; if (lfsr_mod !== 3'd0) begin fails++; $display("FAIL reset_mod got %h want 0", lfsr_mod); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({lfsr_rst, busy, done, aborted, result, sig} !== {4'b1000, 8'h00}) begin
            fails++; $display("FAIL idle_after_reset got %b/%h/%h want 1000/0/0",
                              {lfsr_rst, busy, done, aborted}, result, sig);
        end
    endtask

    task automatic test_basic();
        q_src = 2; q_const = 4'h5;
        launch(8'd3, 3'b010, 8, -1, -1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]} !== exp_flags(k, 3, -1)) begin
                fails++; $display("FAIL basic_profile k=%0d got %b want %b", k,
                                  {tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]}, exp_flags(k, 3, -1));
            end
            checks++;
            if (tr_mod[k] !== 3'b010) begin
                fails++; $display("FAIL basic_mod k=%0d got %b want 010", k, tr_mod[k]);
            end
        end
        checks++; if (tr_res[6] !== 4'h5) begin fails++; $display("FAIL basic_result got %h want 5", tr_res[6]); end
        checks++; if (tr_sig[6] !== 4'hA) begin fails++; $display("FAIL basic_sig got %h want a", tr_sig[6]); end
        checks++; if (tr_sig[8] !== 4'hA) begin fails++; $display("FAIL basic_sig_hold got %h want a", tr_sig[8]); end
        exp_res_last = 4'h5;
        q_src = 0;
    endtask

    task automatic test_zero_len();
        launch(8'd0, 3'b101, 4, -1, -1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]} !== exp_flags(k, 0, -1)) begin
                fails++; $display("FAIL zero_profile k=%0d got %b want %b", k,
                                  {tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]}, exp_flags(k, 0, -1));
            end
        end
        checks++; if (tr_res[1] !== 4'h0) begin fails++; $display("FAIL zero_result got %h want 0", tr_res[1]); end
        checks++; if (tr_sig[1] !== 4'h0) begin fails++; $display("FAIL zero_sig got %h want 0", tr_sig[1]); end
        checks++; if (tr_mod[1] !== 3'b101) begin fails++; $display("FAIL zero_mod got %b want 101", tr_mod[1]); end
        exp_res_last = 4'h0;
    endtask

    task automatic test_abort_and_ignored_start();
        logic [7:0] l2;
        // Abort in the 4th RUN cycle.
        launch(8'd10, 3'b011, 12, C + 4, -1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if ({tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]} !== exp_flags(k, 10, C + 4)) begin
                fails++; $display("FAIL abort_profile k=%0d got %b want %b", k,
                                  {tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]}, exp_flags(k, 10, C + 4));
            end
        end
        checks++;
        if (tr_res[12] !== exp_res_last) begin
            fails++; $display("FAIL abort_result_kept got %h want %h", tr_res[12], exp_res_last);
        end
        // Abort while idle does nothing.
        abort = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, aborted, done} !== 3'b000) begin
            fails++; $display("FAIL idle_abort got %b want 000", {busy, aborted, done});
        end
        abort = 1'b0;
        // Start during RUN is dropped; run completes normally.
        l2 = 8'd5;
        launch(l2, 3'b110, C + 5 + 4, -1, C + 2, 1'b0);
        for (int k = 1; k <= C + 5 + 4; k++) begin
            checks++;
            if ({tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]} !== exp_flags(k, 5, -1)) begin
                fails++; $display("FAIL ignored_start_profile k=%0d got %b want %b", k,
                                  {tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]}, exp_flags(k, 5, -1));
            end
        end
        checks++;
        if (tr_res[C + 6] !== tr_q[C + 5]) begin
            fails++; $display("FAIL ignored_start_result got %h want %h", tr_res[C + 6], tr_q[C + 5]);
        end
        checks++;
        if (tr_sig[C + 6] !== model_sig(C + 1, 5)) begin
            fails++; $display("FAIL ignored_start_sig got %h want %h", tr_sig[C + 6], model_sig(C + 1, 5));
        end
        // Start and abort together in IDLE: start wins.
        launch(8'd2, 3'b001, C + 4, -1, -1, 1'b1);
        for (int k = 1; k <= C + 4; k++) begin
            checks++;
            if ({tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]} !== exp_flags(k, 2, -1)) begin
                fails++; $display("FAIL start_abort_profile k=%0d got %b want %b", k,
                                  {tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]}, exp_flags(k, 2, -1));
            end
        end
        exp_res_last = tr_q[C + 2];
    endtask

    task automatic test_random_runs();
        for (int it = 0; it < 8; it++) begin
            int l, dk;
            logic [2:0] m;
            logic [3:0] er, es;
            l  = $urandom_range(0, 20);
            m  = 3'($urandom);
            dk = (l == 0) ? 1 : C + l + 1;
            launch(8'(l), m, dk + 2, -1, -1, 1'b0);
            for (int k = 1; k <= dk + 2; k++) begin
                checks++;
                if ({tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]} !== exp_flags(k, l, -1)) begin
                    fails++; $display("FAIL rand_profile len=%0d k=%0d got %b want %b", l, k,
                                      {tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]}, exp_flags(k, l, -1));
                end
            end
            er = (l == 0) ? 4'h0 : tr_q[C + l];
            es = (l == 0) ? 4'h0 : model_sig(C + 1, l);
            checks++;
            if ({tr_mod[dk], tr_res[dk], tr_sig[dk]} !== {m, er, es}) begin
                fails++; $display("FAIL rand_outputs len=%0d got mod=%b res=%h sig=%h want mod=%b res=%h sig=%h",
                                  l, tr_mod[dk], tr_res[dk], tr_sig[dk], m, er, es);
            end
            exp_res_last = er;
        end
    endtask

    task automatic test_max_len();
        int dk;
        q_src = 1; lstate = 4'h1;
        launch(8'd255, 3'b100, 260, -1, -1, 1'b0);
        dk = -1;
        for (int k = 260; k >= 1; k--) if (tr_done[k] === 1'b1) dk = k;
        checks++;
        if (dk != 258) begin fails++; $display("FAIL max_done_cycle got %0d want 258", dk); end
        for (int k = 1; k <= 260; k++) begin
            checks++;
            if ({tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]} !== exp_flags(k, 255, -1)) begin
                fails++; $display("FAIL max_profile k=%0d got %b want %b", k,
                                  {tr_rst[k], tr_busy[k], tr_done[k], tr_abt[k]}, exp_flags(k, 255, -1));
            end
        end
        checks++;
        if (tr_res[258] !== tr_q[C + 255]) begin
            fails++; $display("FAIL max_result got %h want %h", tr_res[258], tr_q[C + 255]);
        end
        checks++;
        if (tr_sig[258] !== model_sig(C + 1, 255)) begin
            fails++; $display("FAIL max_sig got %h want %h", tr_sig[258], model_sig(C + 1, 255));
        end
        q_src = 0;
    endtask

    task automatic test_reset_mid_run();
        launch(8'd20, 3'b111, C + 4, -1, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lfsr_rst, busy, done, aborted, lfsr_mod, result, sig} !== {4'b1000, 3'd0, 8'h00}) begin
            fails++; $display("FAIL midrun_reset got %b mod=%b res=%h sig=%h want 1000 mod=000 res=0 sig=0",
                              {lfsr_rst, busy, done, aborted}, lfsr_mod, result, sig);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({lfsr_rst, busy, done} !== 3'b100) begin
            fails++; $display("FAIL midrun_idle got %b want 100", {lfsr_rst, busy, done});
        end
`ifdef LFSR_RUN_CTRL_RUNCOUNT_EN
        checks++;
        if (run_count !== 8'd0) begin fails++; $display("FAIL run_count_reset got %0d want 0", run_count); end
        for (int i = 0; i < 3; i++) launch(8'd1, 3'b001, 5, -1, -1, 1'b0);
        launch(8'd5, 3'b001, 6, C + 1, -1, 1'b0);
        checks++;
        if (run_count !== 8'd3) begin fails++; $display("FAIL run_count_total got %0d want 3", run_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_abort_and_ignored_start();
        test_random_runs();
        test_max_len();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
